// File: rtl/quad_core_top_control_if.sv
// External host port of quad_core_top_control: mode requests, IRAM/DRAM load strobes and readback.
interface quad_core_top_control_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              start_2;
    logic              start_3;
    logic              start_4;
    logic [ADDR_W-1:0] addr_ext;
    logic [DATA_W-1:0] Data_in_ins;
    logic              iram_write_ext_1;
    logic              iram_write_ext_2;
    logic              iram_write_ext_3;
    logic              iram_write_ext_4;
    logic [DATA_W-1:0] Data_in_dram;
    logic              dram_write_ext;
    logic              read_en_ext;
    logic [DATA_W-1:0] dram_in_1;
    logic              all_done;

    modport master (
        output start, start_2, start_3, start_4, addr_ext, Data_in_ins,
               iram_write_ext_1, iram_write_ext_2, iram_write_ext_3, iram_write_ext_4,
               Data_in_dram, dram_write_ext, read_en_ext,
        input  dram_in_1, all_done
    );

    modport slave (
        input  start, start_2, start_3, start_4, addr_ext, Data_in_ins,
               iram_write_ext_1, iram_write_ext_2, iram_write_ext_3, iram_write_ext_4,
               Data_in_dram, dram_write_ext, read_en_ext,
        output dram_in_1, all_done
    );
endinterface

// File: rtl/quad_core_top_control.sv
// Four 16-bit accumulator cores, each with a private IRAM, sharing one arbitrated DRAM.
// Define ARB_FIXED_PRIORITY_EN for fixed core1-first DRAM arbitration (default: round-robin).
module quad_core_top_control #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned IRAM_DEPTH = 512,
    parameter int unsigned DRAM_DEPTH = 512
) (
    input logic                    clock,
    input logic                    reset,
    quad_core_top_control_if.slave ext
);
    typedef enum logic [2:0] {ModeIdle, ModeLoadI, ModeLoadD, ModeRead, ModeRun} mode_e;
    typedef enum logic [1:0] {StFetch, StExec, StWaitR, StHalt} core_st_e;

    // Core ISA: [15:12] opcode, [11:0] immediate or DRAM address (low ADDR_W bits)
    localparam logic [3:0] OpLdi  = 4'h1;
    localparam logic [3:0] OpSt   = 4'h2;
    localparam logic [3:0] OpLd   = 4'h3;
    localparam logic [3:0] OpAddi = 4'h4;
    localparam logic [3:0] OpHalt = 4'hF;

    mode_e                   mode;
    logic                    core_rst;
    logic [3:0]              iram_we;
    logic [3:0]              core_req;
    logic [3:0]              core_we;
    logic [3:0]              core_done;
    logic [3:0][ADDR_W-1:0]  core_addr;
    logic [3:0][DATA_W-1:0]  core_wdata;
    logic [3:0]              req_run;
    logic [3:0]              arb_gnt;
    logic [1:0]              arb_base;
    logic [1:0]              arb_idx;
    logic [1:0]              arb_cand;
    logic                    arb_any;
    logic [DATA_W-1:0]       dram [DRAM_DEPTH];
    logic                    dram_we;
    logic [ADDR_W-1:0]       dram_waddr;
    logic [DATA_W-1:0]       dram_wdata;
    logic [DATA_W-1:0]       dram_rdata_q;
    logic [DATA_W-1:0]       dram_in_1_q;
    logic [3:0]              rvalid_q;
    logic [3:0]              seen_q;
    logic                    all_done_q;

    always_comb begin
        mode = ModeIdle;
        if (reset)             mode = ModeIdle;
        else if (ext.start)    mode = ModeRun;
        else if (ext.start_4)  mode = ModeRead;
        else if (ext.start_3)  mode = ModeLoadD;
        else if (ext.start_2)  mode = ModeLoadI;
    end

    // Cores only run while start is held; dropping it parks them in reset.
    assign core_rst = reset | ~ext.start;
    assign iram_we  = (mode == ModeLoadI) ?
                      {ext.iram_write_ext_4, ext.iram_write_ext_3,
                       ext.iram_write_ext_2, ext.iram_write_ext_1} : 4'b0000;
    assign req_run  = (mode == ModeRun) ? core_req : 4'b0000;

    // First requester at or after arb_base wins.
    always_comb begin
        arb_gnt  = '0;
        arb_idx  = arb_base;
        arb_cand = arb_base;
        arb_any  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            arb_cand = arb_base + 2'(i);
            if (!arb_any && req_run[arb_cand]) begin
                arb_any = 1'b1;
                arb_idx = arb_cand;
            end
        end
        if (arb_any) arb_gnt[arb_idx] = 1'b1;
    end

`ifdef ARB_FIXED_PRIORITY_EN
    assign arb_base = 2'd0;
`else
    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    assign ptr_d    = arb_any ? arb_idx + 2'd1 : ptr_q;
    assign arb_base = ptr_q;

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        dram_we    = 1'b0;
        dram_waddr = ext.addr_ext;
        dram_wdata = ext.Data_in_dram;
        if (mode == ModeRun) begin
            dram_we    = arb_any & core_we[arb_idx];
            dram_waddr = core_addr[arb_idx];
            dram_wdata = core_wdata[arb_idx];
        end else if (mode == ModeLoadD) begin
            dram_we    = ext.dram_write_ext;
        end
    end

    always_ff @(posedge clock) begin
        if (dram_we) dram[dram_waddr] <= dram_wdata;
        dram_rdata_q <= dram[core_addr[arb_idx]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dram_in_1_q <= '0;
        end else if (mode == ModeRead && ext.read_en_ext) begin
            dram_in_1_q <= dram[ext.addr_ext];
        end
    end

    always_ff @(posedge clock) begin
        if (core_rst) begin
            rvalid_q   <= '0;
            seen_q     <= '0;
            all_done_q <= 1'b0;
        end else begin
            rvalid_q   <= arb_gnt & ~core_we;
            seen_q     <= seen_q | core_done;
            all_done_q <= &(seen_q | core_done);
        end
    end

    assign ext.dram_in_1 = dram_in_1_q;
    assign ext.all_done  = all_done_q;

    for (genvar g = 0; g < 4; g++) begin : g_core
        logic [DATA_W-1:0] iram [IRAM_DEPTH];
        logic [DATA_W-1:0] ins_q;
        logic [DATA_W-1:0] acc_q;
        logic [DATA_W-1:0] acc_d;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] pc_q;
        logic [ADDR_W-1:0] pc_d;
        logic [3:0]        opc;
        core_st_e          st_q;
        core_st_e          st_d;
        logic              req;
        logic              we;

        assign opc = ins_q[DATA_W-1 -: 4];
        assign imm = DATA_W'(ins_q[11:0]);

        // Fetch port reads the word at pc every cycle; it is valid one cycle after pc settles.
        always_ff @(posedge clock) begin
            if (iram_we[g]) iram[ext.addr_ext] <= ext.Data_in_ins;
            ins_q <= iram[pc_q];
        end

        always_ff @(posedge clock) begin
            if (core_rst) begin
                st_q  <= StFetch;
                pc_q  <= ADDR_W'(1);
                acc_q <= '0;
            end else begin
                st_q  <= st_d;
                pc_q  <= pc_d;
                acc_q <= acc_d;
            end
        end

        always_comb begin
            st_d  = st_q;
            pc_d  = pc_q;
            acc_d = acc_q;
            req   = 1'b0;
            we    = 1'b0;
            unique case (st_q)
                StFetch: st_d = StExec;
                StExec: begin
                    case (opc)
                        OpLdi: begin
                            acc_d = imm;
                            pc_d  = pc_q + ADDR_W'(1);
                            st_d  = StFetch;
                        end
                        OpAddi: begin
                            acc_d = acc_q + imm;
                            pc_d  = pc_q + ADDR_W'(1);
                            st_d  = StFetch;
                        end
                        OpSt: begin
                            req = 1'b1;
                            we  = 1'b1;
                            if (arb_gnt[g]) begin
                                pc_d = pc_q + ADDR_W'(1);
                                st_d = StFetch;
                            end
                        end
                        OpLd: begin
                            req = 1'b1;
                            if (arb_gnt[g]) st_d = StWaitR;
                        end
                        OpHalt: st_d = StHalt;
                        default: begin
                            pc_d = pc_q + ADDR_W'(1);
                            st_d = StFetch;
                        end
                    endcase
                end
                StWaitR: begin
                    if (rvalid_q[g]) begin
                        acc_d = dram_rdata_q;
                        pc_d  = pc_q + ADDR_W'(1);
                        st_d  = StFetch;
                    end
                end
                StHalt: st_d = StHalt;
            endcase
        end

        assign core_req[g]   = req;
        assign core_we[g]    = we;
        assign core_addr[g]  = ins_q[ADDR_W-1:0];
        assign core_wdata[g] = acc_q;
        assign core_done[g]  = (st_q == StHalt);
    end
endmodule

// File: tb/tb_quad_core_top_control.sv
// Bench for quad_core_top_control: vector table, randomized host traffic and core programs
// checked against a word-level model of the memories and an instruction-level core interpreter.
module tb_quad_core_top_control;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 16;

    typedef struct {
        logic [2:0]    mode;   // {start_4, start_3, start_2}
        logic [3:0]    strb;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] ins;
        logic [DW-1:0] dd;
        logic [DW-1:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    quad_core_top_control_if bus ();
    quad_core_top_control dut (.clock(clock), .reset(reset), .ext(bus.slave));

    int            nvec = 0;
    int            nerr = 0;
    logic [DW-1:0] dram_m [512];
    logic [DW-1:0] dout_m;
    int            grants[$];
    vec_t          tbl [9];
    logic [DW-1:0] prog [4][16];
    int            plen [4];
    logic [31:0]   r;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic set_strb(logic [3:0] s);
        bus.iram_write_ext_1 = s[0];
        bus.iram_write_ext_2 = s[1];
        bus.iram_write_ext_3 = s[2];
        bus.iram_write_ext_4 = s[3];
    endtask

    task automatic idle();
        bus.start = 1'b0; bus.start_2 = 1'b0; bus.start_3 = 1'b0; bus.start_4 = 1'b0;
        bus.addr_ext = '0; bus.Data_in_ins = '0; bus.Data_in_dram = '0;
        bus.dram_write_ext = 1'b0; bus.read_en_ext = 1'b0;
        set_strb(4'b0000);
    endtask

    // Model: mode priority and host-side memory effects of the coming edge.
    task automatic tick();
        if (reset) begin
            dout_m = '0;
        end else if (!bus.start) begin
            if (bus.start_4) begin
                if (bus.read_en_ext) dout_m = dram_m[bus.addr_ext];
            end else if (bus.start_3) begin
                if (bus.dram_write_ext) dram_m[bus.addr_ext] = bus.Data_in_dram;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic dram_write(int a, logic [DW-1:0] d);
        idle(); bus.start_3 = 1'b1; bus.dram_write_ext = 1'b1;
        bus.addr_ext = AW'(a); bus.Data_in_dram = d;
        tick(); idle();
    endtask

    task automatic iram_write(logic [3:0] s, int a, logic [DW-1:0] d);
        idle(); bus.start_2 = 1'b1; set_strb(s);
        bus.addr_ext = AW'(a); bus.Data_in_ins = d;
        tick(); idle();
    endtask

    task automatic read_chk(string name, int a);
        idle(); bus.start_4 = 1'b1; bus.read_en_ext = 1'b1; bus.addr_ext = AW'(a);
        tick();
        check(name, bus.dram_in_1, dout_m);
        idle();
    endtask

    function automatic logic [DW-1:0] peek(int c, int a);
        case (c)
            0:       return dut.g_core[0].iram[a];
            1:       return dut.g_core[1].iram[a];
            2:       return dut.g_core[2].iram[a];
            default: return dut.g_core[3].iram[a];
        endcase
    endfunction

    task automatic load_progs();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < plen[c]; i++) iram_write(4'(1 << c), i + 1, prog[c][i]);
    endtask

    // Instruction-level interpretation of one core's program against the DRAM model.
    task automatic model_prog(int c);
        logic [DW-1:0] acc;
        logic [DW-1:0] w;
        acc = '0;
        for (int i = 0; i < plen[c]; i++) begin
            w = prog[c][i];
            if (w[15:12] == 4'hF) break;
            case (w[15:12])
                4'h1: acc = {4'h0, w[11:0]};
                4'h4: acc = acc + {4'h0, w[11:0]};
                4'h2: dram_m[w[8:0]] = acc;
                4'h3: acc = dram_m[w[8:0]];
                default: ;
            endcase
        end
    endtask

    task automatic run_cores(string name, bit noise);
        int cyc;
        cyc = 0;
        grants.delete();
        idle();
        if (noise) begin
            bus.start_3 = 1'b1; bus.start_4 = 1'b1; bus.dram_write_ext = 1'b1;
            bus.read_en_ext = 1'b1; bus.addr_ext = AW'(7); bus.Data_in_dram = 16'hDEAD;
        end
        bus.start = 1'b1;
        while (cyc < 400) begin
            for (int i = 0; i < 4; i++) if (dut.arb_gnt[i]) grants.push_back(i + 1);
            if (bus.all_done) break;
            tick();
            cyc++;
        end
        check({name, "_all_done"}, bus.all_done, 1);
        idle();
        tick();
        check({name, "_all_done_clr"}, bus.all_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        idle();
        reset  = 1'b1;
        dout_m = '0;
        repeat (3) tick();
        check("rst_dout", bus.dram_in_1, 0);
        check("rst_all_done", bus.all_done, 0);
        reset = 1'b0;

        for (int a = 0; a < 512; a++) dram_write(a, 16'(a * 37 + 5));

        // IRAM load: other cores preloaded first, then strobe 1 alone.
        for (int c = 1; c < 4; c++)
            for (int a = 1; a <= 3; a++) iram_write(4'(1 << c), a, 16'(16'h0100 * (c + 1) + a));
        for (int c = 0; c < 4; c++) iram_write(4'(1 << c), 6, 16'(16'hC001 + c));
        for (int a = 1; a <= 3; a++) iram_write(4'b0001, a, 16'(10 * a));
        for (int a = 1; a <= 3; a++) check("loadi_iram1", peek(0, a), 10 * a);
        for (int c = 1; c < 4; c++)
            for (int a = 1; a <= 3; a++)
                check("loadi_other_iram", peek(c, a), 16'h0100 * (c + 1) + a);

        tbl[0] = '{3'b010, 4'b0000, 1'b1, 1'b0, 9'd5, 16'h0000, 16'h1234, 16'h0000};
        tbl[1] = '{3'b100, 4'b0000, 1'b0, 1'b1, 9'd5, 16'h0000, 16'h0000, 16'h1234};
        tbl[2] = '{3'b100, 4'b0000, 1'b0, 1'b0, 9'd6, 16'h0000, 16'h0000, 16'h1234};
        tbl[3] = '{3'b011, 4'b0001, 1'b1, 1'b0, 9'd6, 16'hBEEF, 16'h5A5A, 16'h1234};
        tbl[4] = '{3'b110, 4'b0000, 1'b1, 1'b1, 9'd6, 16'h0000, 16'h7777, 16'h5A5A};
        tbl[5] = '{3'b100, 4'b0000, 1'b0, 1'b1, 9'd6, 16'h0000, 16'h0000, 16'h5A5A};
        tbl[6] = '{3'b001, 4'b0001, 1'b1, 1'b1, 9'd5, 16'h0A0A, 16'h0000, 16'h5A5A};
        tbl[7] = '{3'b000, 4'b0001, 1'b1, 1'b1, 9'd5, 16'hFFFF, 16'h1111, 16'h5A5A};
        tbl[8] = '{3'b100, 4'b0000, 1'b0, 1'b1, 9'd5, 16'h0000, 16'h0000, 16'h1234};
        for (int i = 0; i < 9; i++) begin
            idle();
            {bus.start_4, bus.start_3, bus.start_2} = tbl[i].mode;
            set_strb(tbl[i].strb);
            bus.dram_write_ext = tbl[i].we;
            bus.read_en_ext    = tbl[i].re;
            bus.addr_ext       = tbl[i].addr;
            bus.Data_in_ins    = tbl[i].ins;
            bus.Data_in_dram   = tbl[i].dd;
            tick();
            check($sformatf("vec%0d_dout", i), bus.dram_in_1, tbl[i].exp);
        end
        idle();
        check("prio_iram1_6", peek(0, 6), 16'hC001);
        check("loadi_iram1_5", peek(0, 5), 16'h0A0A);

        for (int n = 0; n < 300; n++) begin
            idle();
            r = $urandom;
            bus.start_2 = r[0]; bus.start_3 = r[1]; bus.start_4 = r[2];
            set_strb(r[7:4]);
            bus.dram_write_ext = r[8];
            bus.read_en_ext    = r[9] | r[10];
            bus.addr_ext       = AW'(16 + $urandom_range(0, 31));
            bus.Data_in_ins    = 16'($urandom);
            bus.Data_in_dram   = 16'($urandom);
            tick();
            check("rnd_ext_dout", bus.dram_in_1, dout_m);
        end
        idle();

        // All four cores reach their store in the same cycle.
        for (int c = 0; c < 4; c++) begin
            plen[c] = 3;
            prog[c][0] = 16'h1000 | 16'(c + 1);
            prog[c][1] = 16'h2000 | 16'd50;
            prog[c][2] = 16'hF000;
        end
        load_progs();
        run_cores("arb", 1'b0);
        check("arb_ngrants", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) check("arb_order", grants[i], i + 1);
        for (int c = 0; c < 4; c++) model_prog(c);
        read_chk("arb_dram50", 50);

        // Store id, reload it, add 16, store again; host traffic held on during the run.
        for (int c = 0; c < 4; c++) begin
            plen[c] = 6;
            prog[c][0] = 16'h1000 | 16'(c + 1);
            prog[c][1] = 16'h2000 | 16'(101 + c);
            prog[c][2] = 16'h3000 | 16'(101 + c);
            prog[c][3] = 16'h4000 | 16'd16;
            prog[c][4] = 16'h2000 | 16'(111 + c);
            prog[c][5] = 16'hF000;
        end
        load_progs();
        run_cores("run", 1'b1);
        check("run_dout_hold", bus.dram_in_1, dout_m);
        for (int c = 0; c < 4; c++) model_prog(c);
        for (int a = 101; a <= 104; a++) check("run_id_model", dram_m[a], a - 100);
        for (int a = 101; a <= 104; a++) read_chk("run_dram_id", a);
        for (int a = 111; a <= 114; a++) read_chk("run_dram_add", a);
        read_chk("run_ext_write_blocked", 7);

        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                plen[c] = $urandom_range(5, 12);
                for (int i = 0; i < plen[c] - 1; i++) begin
                    r = 32'(256 + 16 * c + $urandom_range(0, 15));
                    case ($urandom_range(0, 3))
                        0: prog[c][i] = 16'h1000 | 16'($urandom_range(0, 4095));
                        1: prog[c][i] = 16'h4000 | 16'($urandom_range(0, 4095));
                        2: prog[c][i] = 16'h2000 | r[15:0];
                        default: prog[c][i] = 16'h3000 | r[15:0];
                    endcase
                end
                prog[c][plen[c] - 1] = 16'hF000;
            end
            load_progs();
            run_cores("rnd_run", 1'b0);
            for (int c = 0; c < 4; c++) model_prog(c);
            for (int a = 256; a < 320; a++) read_chk("rnd_run_dram", a);
        end

        read_chk("pre_rst_read", 101);
        idle();
        reset = 1'b1; bus.start_4 = 1'b1; bus.read_en_ext = 1'b1; bus.addr_ext = AW'(5);
        tick();
        check("rst_mid_read_dout", bus.dram_in_1, 0);
        check("rst_mid_read_done", bus.all_done, 0);
        reset = 1'b0;
        read_chk("post_rst_dram5", 5);
        check("post_rst_model5", dram_m[5], 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
